// File: rtl/rand_io_pkg.sv
// Shared constants, lane seeding and LFSR/MISR step helpers for the random-stimulus harness.
package rand_io_pkg;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;
    localparam logic [31:0] MISR_MASK = LFSR_MASK;

    typedef enum logic [1:0] {
        GEN_FREE   = 2'b00,
        GEN_STEP   = 2'b01,
        GEN_HOLD   = 2'b10,
        GEN_RESEED = 2'b11
    } gen_mode_e;

    // A zero seed would lock the Galois LFSR at zero forever, so it is replaced.
    function automatic logic [31:0] lane_seed(input logic [31:0] g, input logic [31:0] base);
        logic [31:0] s;
        s = (GOLDEN * (g + 32'd1)) + base;
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'd0);
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] fold);
        return ({1'b0, s[31:1]} ^ (s[0] ? MISR_MASK : 32'd0)) ^ fold;
    endfunction

endpackage

// File: rtl/rand_lane_gen.sv
// One 32-bit Galois LFSR lane; load restores the compile-time seed and wins over adv.
module rand_lane_gen
    import rand_io_pkg::*;
#(
    parameter logic [31:0] SEED = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adv,
    input  logic        load,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next lane state: reseed, advance or hold.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (adv) begin
            state_d = lfsr_step(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // Lane state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rand_io_harness.sv
// Pin-limited wrapper harness: seeded LFSR write-data lanes, registered slice readback and
// a 32-bit MISR that folds all read data so the wrapped logic survives synthesis.
module rand_io_harness
    import rand_io_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          DATA_W    = 256,
    parameter int          OUT_W     = 8,
    parameter logic [31:0] SEED_BASE = 32'd0,
    localparam int         NSLICE    = NUM_CH * DATA_W / OUT_W,
    localparam int         SEL_W     = $clog2(NSLICE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               gen_mode,
    input  logic                     gen_step,
    output logic [NUM_CH*DATA_W-1:0] wdata,
    input  logic [NUM_CH*DATA_W-1:0] rdata,
    input  logic [SEL_W-1:0]         out_sel,
    output logic [OUT_W-1:0]         out,
    input  logic                     sig_en,
    input  logic                     sig_clr,
    output logic [31:0]              sig,
    output logic [15:0]              sig_cnt
);

    localparam int LANES = DATA_W / 32;
    localparam int NLANE = NUM_CH * LANES;

    gen_mode_e        mode_s;
    logic             adv_s;
    logic             load_s;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;
    logic [31:0]      fold_s;
    logic [31:0]      sig_d;
    logic [31:0]      sig_q;
    logic [15:0]      cnt_d;
    logic [15:0]      cnt_q;

    assign mode_s = gen_mode_e'(gen_mode);

    // Decode the generator mode into per-lane advance/load strobes.
    always_comb begin
        adv_s  = 1'b0;
        load_s = 1'b0;
        case (mode_s)
            GEN_FREE:   adv_s  = 1'b1;
            GEN_STEP:   adv_s  = gen_step;
            GEN_HOLD:   adv_s  = 1'b0;
            GEN_RESEED: load_s = 1'b1;
            default: begin
                adv_s  = 1'b0;
                load_s = 1'b0;
            end
        endcase
    end

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        rand_lane_gen #(
            .SEED (lane_seed(32'(g), SEED_BASE))
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .adv   (adv_s),
            .load  (load_s),
            .state (wdata[g*32 +: 32])
        );
    end

    // Slice mux built from valid indices only, so an out-of-range select yields zero.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < NSLICE; i++) begin
            out_d = out_d | ((out_sel == SEL_W'(i)) ? rdata[i*OUT_W +: OUT_W] : '0);
        end
    end

    // XOR of every 32-bit lane of read data across all channels.
    always_comb begin
        fold_s = 32'd0;
        for (int g = 0; g < NLANE; g++) begin
            fold_s = fold_s ^ rdata[g*32 +: 32];
        end
    end

    // Signature and saturating accept counter; clear wins over enable.
    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (sig_clr) begin
            sig_d = 32'd0;
            cnt_d = 16'd0;
        end else if (sig_en) begin
            sig_d = misr_step(sig_q, fold_s);
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
        end else begin
            sig_d = sig_q;
            cnt_d = cnt_q;
        end
    end

    // Readback and signature registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            sig_q <= 32'd0;
            cnt_q <= 16'd0;
        end else begin
            out_q <= out_d;
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end

    assign out     = out_q;
    assign sig     = sig_q;
    assign sig_cnt = cnt_q;

endmodule
